// File: rtl/sprite_pkg.sv
// Shared definitions for the mouse sprite path.
// Holds the sprite geometry constants and the loader FSM state encoding
// so that the loader and anything observing its state agree on one type.
package sprite_pkg;

    localparam int H_SIZE   = 128;
    localparam int V_SIZE   = 128;
    localparam int SPR_ADDR = 14;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } loader_state_t;

endpackage

// File: rtl/bit_unpacker.sv
// One-byte buffer that hands out its bits one at a time, bit 0 first.
// Ports:
//   clk, reset - rising-edge clock, synchronous active-high reset
//   clear      - empty the buffer and rewind the index (start of an upload)
//   load       - capture data; the buffer becomes full with idx = 0
//   data       - byte to capture on load
//   shift      - the current bit has been consumed; advance idx
//   full       - the buffer holds unconsumed bits
//   idx        - index of the bit currently presented
//   bit_out    - the bit at idx
module bit_unpacker (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       shift,
    output logic       full,
    output logic [2:0] idx,
    output logic       bit_out
);

    logic [7:0] shift_buf;

    // load wins over shift: when bit 7 is consumed in the same cycle that a
    // new byte arrives, the buffer refills directly and stays full.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_buf <= '0;
            full      <= 1'b0;
            idx       <= '0;
        end else if (load) begin
            shift_buf <= data;
            full      <= 1'b1;
            idx       <= '0;
        end else if (shift && full) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
                full <= 1'b0;
            end
        end
    end

    assign bit_out = shift_buf[idx];

endmodule

// File: rtl/sprite_ram_loader.sv
// Streams a packed 1-bit-per-pixel image into the sprite RAM.
// Each accepted byte becomes eight sequential RAM writes, bit 0 first,
// covering addresses 0 .. 2^ADDR-1 once per upload.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   start          - begin an upload (only acted on while idle)
//   s_data/s_valid - packed pixel byte stream, s_ready is the loader side
//   we/addr_w/pixel_in - registered sprite RAM write port
//   busy           - upload in progress
//   done           - one-cycle pulse after the final write
//   fsm_state      - current loader state, for observation
//
// Handshake: a byte moves on a rising edge where s_valid and s_ready are both
// 1. s_ready depends only on state and registers, never on s_valid; the
// source must hold s_data stable while s_valid is 1 and s_ready is 0.
module sprite_ram_loader
    import sprite_pkg::*;
#(
    parameter int ADDR = SPR_ADDR,
    parameter int CD   = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            we,
    output logic [ADDR-1:0] addr_w,
    output logic [CD-1:0]   pixel_in,
    output logic            busy,
    output logic            done,
    output loader_state_t   fsm_state
);

    localparam logic [ADDR-1:0] LAST_ADDR = '1;

    loader_state_t   state;
    loader_state_t   state_next;
    logic [ADDR-1:0] addr_cnt;
    logic            full;
    logic [2:0]      idx;
    logic            bit_out;
    logic            fire;
    logic            accept;
    logic            clear;
    logic            at_last;
    logic            final_seen;

    // fire: a pixel is written this edge (registered onto the RAM port).
    assign fire       = (state == LOAD) && full;
    assign accept     = s_valid && s_ready;
    assign at_last    = (addr_cnt == LAST_ADDR);
    // The last write is visible on the port; the upload is complete and no
    // further byte may be taken while the FSM steps to DONE.
    assign final_seen = we && (addr_w == LAST_ADDR);
    assign fsm_state  = state;

    bit_unpacker u_unpacker (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .load    (accept),
        .data    (s_data),
        .shift   (fire),
        .full    (full),
        .idx     (idx),
        .bit_out (bit_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                // Taking a byte while bit 7 is written keeps writes
                // back-to-back, except when bit 7 is the last pixel.
                s_ready = !final_seen && (!full || (idx == 3'd7 && !at_last));
                if (final_seen) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write port and address counter. The counter stops at the last
    // address rather than wrapping; the buffer is empty by then anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            we       <= 1'b0;
            addr_w   <= '0;
            pixel_in <= '0;
            addr_cnt <= '0;
        end else begin
            we <= fire;
            if (clear) begin
                addr_cnt <= '0;
            end else if (fire && !at_last) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
            if (fire) begin
                addr_w   <= addr_cnt;
                pixel_in <= {{(CD-1){1'b0}}, bit_out};
            end
        end
    end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: reset values, idle refusal, a full
// timed upload, stalled upload with a stray start, and reset mid-upload.
module tb_sprite_ram_loader;
    import sprite_pkg::*;

    localparam int ADDR   = 14;
    localparam int CD     = 12;
    localparam int NBYTES = 2048;
    localparam int NPIX   = NBYTES * 8;
    localparam int LIMIT  = 30000;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [7:0]      s_data;
    logic            s_valid;
    logic            s_ready;
    logic            we;
    logic [ADDR-1:0] addr_w;
    logic [CD-1:0]   pixel_in;
    logic            busy;
    logic            done;
    loader_state_t   fsm_state;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];
    int exp_addr;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sprite_ram_loader #(.ADDR(ADDR), .CD(CD)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .we        (we),
        .addr_w    (addr_w),
        .pixel_in  (pixel_in),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pattern(input int sel, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        if (sel == 0) return 8'hA5;
        return kb ^ 8'h5A;
    endfunction

    // ---------------- driver / scoreboard ----------------
    // Inputs change and outputs are sampled on the falling edge. The loop
    // variable cyc counts rising edges since the one that sampled start.
    task automatic upload(input int sel, input bit stall, input int start_at,
                          input int abort_at, input bit timing);
        int   cyc = 0;
        int   nacc = 0;
        int   stall_left = 0;
        bit   acc_prev = 1'b0;
        bit   finished = 1'b0;
        bit   aborted = 1'b0;
        bit   saw_done = 1'b0;
        logic [7:0] b;
        logic [0:0] bit_exp;
        exp_q.delete();
        exp_addr = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1);
        while (!finished && cyc < LIMIT) begin
            start = 1'b0;
            if (we) begin
                if (timing && exp_addr == 0) check("first_we_cycle", cyc, 2);
                check("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    bit_exp = exp_q.pop_front();
                    check("pixel", pixel_in, {{(CD-1){1'b0}}, bit_exp});
                end
                check("addr", addr_w, exp_addr);
                if (exp_addr == NPIX - 1) check("ready_last_write", s_ready, 0);
                if (exp_addr == start_at) start = 1'b1;
                if (exp_addr == abort_at) begin
                    reset    = 1'b1;
                    aborted  = 1'b1;
                    finished = 1'b1;
                end
                exp_addr++;
            end else if (busy) begin
                check("we_gap_only_when_empty", 32'(exp_q.size() == 0 || acc_prev), 1);
            end
            if (done) begin
                if (timing) check("done_cycle", cyc, NPIX + 2);
                check("busy_at_done", busy, 0);
                check("state_done", fsm_state, DONE);
                check("all_written", exp_addr, NPIX);
                check("bytes_taken", nacc, NBYTES);
                saw_done = 1'b1;
                finished = 1'b1;
            end
            if (!finished) begin
                if (stall_left > 0) begin
                    s_valid = 1'b0;
                    if (s_ready) stall_left--;
                end else begin
                    s_valid = 1'b1;
                    s_data  = pattern(sel, nacc);
                end
                acc_prev = s_valid && s_ready;
                if (acc_prev) begin
                    b = s_data;
                    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
                    nacc++;
                    if (stall && (nacc % 3 == 0)) stall_left = 5;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            check("abort_we", we, 0);
            check("abort_busy", busy, 0);
            check("abort_addr", addr_w, 0);
            check("abort_state", fsm_state, IDLE);
            reset   = 1'b0;
            s_valid = 1'b0;
        end else if (saw_done) begin
            // s_valid is still high with an extra byte offered here.
            check("state_idle_after_done", fsm_state, IDLE);
            check("done_one_cycle", done, 0);
            for (int i = 0; i < 3; i++) begin
                check("extra_not_taken", s_ready, 0);
                check("no_write_after_done", we, 0);
                @(negedge clk);
            end
            s_valid = 1'b0;
        end else begin
            check("upload_finished", finished, 1);
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_we", we, 0);
        check("rst_addr", addr_w, 0);
        check("rst_pixel", pixel_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", s_ready, 0);
        check("rst_state", fsm_state, IDLE);
        reset = 1'b0;
        @(negedge clk);

        // Bytes offered in IDLE without start are never taken.
        s_valid = 1'b1;
        s_data  = 8'hFF;
        for (int i = 0; i < 100; i++) begin
            check("idle_ready_we", {s_ready, we}, 2'b00);
            @(negedge clk);
        end
        s_valid = 1'b0;
        @(negedge clk);

        upload(0, 1'b0, -1, -1, 1'b1);     // full A5 upload, timed
        upload(1, 1'b1, 100, -1, 1'b0);    // stalls, stray start at 100
        upload(1, 1'b0, -1, 5000, 1'b0);   // reset during write of 5000
        upload(0, 1'b0, -1, 63, 1'b0);     // restart begins at address 0

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_ram_loader.md
# sprite_ram_loader

Upstream feeder for the 128×128, 1-bit-per-pixel sprite RAM inside the mouse sprite source. It accepts a packed byte stream over a valid/ready handshake, unpacks each byte into eight pixel codes, and issues sequential sprite-RAM writes (`we`, `addr_w`, `pixel_in`) covering all 16384 locations. It reports busy/done so the top-level controller can sequence sprite uploads, e.g. from UART or ROM, between frames.

## Interface
Parameters:
- `ADDR`, 14: sprite RAM address width; the full image is 2^ADDR pixels.
- `CD`, 12: width of `pixel_in`; bit 0 carries the pixel code and bits CD-1..1 are 0.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins an upload; honoured only in IDLE.
- `s_data`  in  8  packed pixel byte; bit 0 is the first pixel.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  the loader accepts `s_data` this cycle.
- `we`  out  1  sprite RAM write enable.
- `addr_w`  out  ADDR  sprite RAM write address, equal to {row[6:0], col[6:0]}.
- `pixel_in`  out  CD  sprite RAM write data.
- `busy`  out  1  an upload is in progress.
- `done`  out  1  one-cycle pulse after the final write.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - `busy`=0 and `s_ready`=0.
  - When `start`=1: clear the address counter to 0, clear the bit index, mark the buffer empty, go to LOAD.
- LOAD:
  - `busy`=1.
  - A byte transfer occurs when `s_valid` and `s_ready` are both 1. The byte is latched into an 8-bit shift buffer and bit index is set to 0.
  - While the buffer is full, emit one write per cycle:
    - `we`=1, `pixel_in`={(CD-1)'b0, buf[idx]}, `addr_w`=address counter.
    - After each write, increment the address counter and idx.
  - When idx=7 is written, the buffer becomes empty unless a new byte is accepted in the same cycle.
  - `s_ready` = buffer empty, or buffer full with idx=7 (last-bit overlap). This allows back-to-back bytes to produce continuous writes.
  - When the write to address 2^ADDR−1 occurs, go to DONE. Any byte accepted in that same cycle is impossible: `s_ready` is forced to 0 when the counter is 2^ADDR−1 and idx=7.
- DONE:
  - `done`=1 for exactly one cycle, `busy`=0; next state is IDLE.
- Stream stalls (`s_valid`=0 with the buffer empty) hold all state; `we`=0.
- `start` outside IDLE is ignored.
- Bytes presented in IDLE or DONE are not accepted and are not consumed.
- The address counter is ADDR bits wide and never wraps inside an upload; the upload ends at the last address.
- `s_data` bits map linearly: byte k, bit b goes to address 8k+b.

## Timing
- Reset values: state=IDLE, `s_ready`=0, `we`=0, `addr_w`=0, `pixel_in`=0, `busy`=0, `done`=0. Reset mid-upload aborts immediately. RAM contents written so far remain in the RAM; the loader does not clear them.
- `we`, `addr_w`, and `pixel_in` are registered.
  - A byte accepted at edge N produces its first write (bit 0) asserted during cycle N+1.
  - Its bit 7 write is asserted during cycle N+8.
- `busy` rises in the cycle after the `start` edge.
- Sustained throughput is 8 writes per 8 cycles with `s_valid` held high, i.e. 2048 bytes → 16384 writes in 16384 cycles, plus 1 cycle of latency.
- `done` is asserted in the cycle after the final `we`; `busy` is 0 in the same cycle as `done`.
- `s_ready` is combinational from state and registers only, not from `s_valid`.

## Structure
- Shared package `sprite_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t`.
  - Constants `H_SIZE`=128, `V_SIZE`=128, `SPR_ADDR`=14.
- One natural sub-module: `bit_unpacker`, an 8-bit shift buffer with full flag, index, and load/shift controls. The FSM and address counter stay in the top.

## Test plan
- Full upload: `start`, then 2048 bytes with `s_valid` held high, data pattern 8'hA5 → 16384 consecutive `we` cycles; `pixel_in` at address 0..7 = 1,0,1,0,0,1,0,1; `done` pulses once at cycle 16386 after `start`; `busy` falls in the same cycle.
- Stalls: deassert `s_valid` for 5 cycles after every 3rd byte → `we` gaps appear only while the buffer is empty; `addr_w` sequence remains gap-free, from 0 to 16383.
- Final-byte boundary: at address 16376, with `s_valid` held high and extra data → `s_ready`=0 during the last write; the extra byte is not consumed; state goes to DONE, then IDLE.
- `start` during LOAD at address 100 → ignored; counter continues to 101 and onward, with no restart.
- Reset at address 5000 during a write → next cycle: `we`=0, `busy`=0, `addr_w`=0; a subsequent `start` begins again from address 0.
- Bytes offered in IDLE with `s_valid`=1 and no `start` → `s_ready`=0 and `we`=0 for 100 cycles.
